vram_rd_arbiter: RTL and testbench
==================================

Name: vram_rd_arbiter

Overview:
- Shares one read-only VRAM port B (param, tile or pal bank group) between the BG renderer (requester 0) and the SP renderer (requester 1).
- Each requester issues reads through a valid/ready handshake.
- Arbitration is round-robin with optional burst locking; a tag pipeline routes each read response back to the requester that issued it.
- Instantiated once per shared RAM in the VPU, between the renderers and the vram port-B pins.

Parameters:
- ADDR_W, 16, RAM word address width.
- DATA_W, 32, RAM data width.
- READ_LAT, 1, RAM read latency in cycles from ram_en to valid ram_dout; legal range 1..3.
- MAX_BURST, 8, maximum consecutive grants to one locked requester before a forced switch; legal range 1..255.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- bg_req_valid  in  1  BG read request
- bg_req_lock  in  1  BG asks to keep ownership for the next beat
- bg_req_addr  in  ADDR_W  BG read address
- bg_req_ready  out  1  BG request accepted this cycle
- bg_rsp_valid  out  1  BG read data valid
- bg_rsp_data  out  DATA_W  BG read data
- sp_req_valid  in  1  SP read request
- sp_req_lock  in  1  SP lock
- sp_req_addr  in  ADDR_W  SP read address
- sp_req_ready  out  1  SP accepted
- sp_rsp_valid  out  1  SP read data valid
- sp_rsp_data  out  DATA_W  SP read data
- ram_en  out  1  RAM port-B enable (registered)
- ram_addr  out  ADDR_W  RAM port-B address (registered)
- ram_we  out  1  tied 0
- ram_dout  in  DATA_W  RAM port-B read data
- busy  out  1  any read outstanding in the tag pipeline

Behaviour:
- Reset (async, rst=1): all outputs 0; state=IDLE; last_owner=SP, so BG wins the first tie; burst_cnt=0; tag pipeline cleared. Reads in flight during reset are dropped with no rsp_valid.
- Handshake: a request is accepted when valid&&ready. req_ready is combinational from the current valid inputs and the state. At most one ready is high per cycle.
- States: IDLE, OWN_BG, OWN_SP.
- IDLE, one valid: grant that requester.
- IDLE, both valid: grant !last_owner.
- On a grant, go to OWN_x and set burst_cnt=1 if that requester's lock is high.
- OWN_x: requester x has absolute priority while x_req_valid&&x_req_lock&&burst_cnt<MAX_BURST; each accepted beat increments burst_cnt.
- Leaving OWN_x: when x drops lock or valid, or burst_cnt reaches MAX_BURST, last_owner=x. Arbitration in that same cycle proceeds as in IDLE, so there is no bubble. If the other requester is valid it wins; x must wait at least one grant.
- A grant without lock leaves the next state as IDLE.
- Issue timing: an acceptance in cycle N drives ram_en=1 and ram_addr=<addr> in cycle N+1. ram_en=0 in every cycle with no acceptance in the previous cycle.
- Response timing: tag shift register of depth 1+READ_LAT holds {valid, owner}. x_rsp_valid=1 and x_rsp_data=ram_dout in cycle N+1+READ_LAT, for exactly one cycle.
- rsp_data holds its last value when rsp_valid=0.
- Throughput: one accepted request per cycle sustained, no backpressure on responses; renderers must always sink rsp.
- busy is the OR of the tag-pipeline valid bits plus ram_en.
- Simultaneous lock assertion by both requesters: the current owner keeps the grant; from IDLE, round-robin decides.
- burst_cnt saturates at MAX_BURST and never wraps.

Optional Feature:
- Macro VRAM_ARB_PERF_EN.
- Defined: adds 32-bit outputs bg_grant_cnt, sp_grant_cnt and conflict_cnt. conflict_cnt increments on cycles where both valid and one is refused. All three reset to 0 and wrap modulo 2^32.
- Undefined: the ports and counters are absent; all other behaviour is identical.

Test Plan:
- Single BG read, addr 0x0010, RAM model returns addr+0x1000, READ_LAT=1 → ram_en at N+1, bg_rsp_valid at N+2 with data 0x1010; sp_rsp_valid stays 0.
- BG and SP both valid continuously, no lock, from reset → grants alternate BG,SP,BG,SP; 8 responses in order with correct owner tags; one request per cycle.
- BG locked with a 12-beat stream, SP valid throughout, MAX_BURST=8 → 8 BG grants, then SP granted, then BG resumes; burst_cnt saturates and does not wrap.
- READ_LAT=3, back-to-back BG,SP,BG → responses at N+4, N+5, N+6 routed BG, SP, BG.
- Assert rst while 2 reads are in the tag pipeline → no rsp_valid during or after reset; busy=0; next request after release is granted to BG on a tie.
- VRAM_ARB_PERF_EN defined, 10 cycles of both valid → bg_grant_cnt=5, sp_grant_cnt=5, conflict_cnt=10.

Source files
------------

// File: rtl/vram_rd_arbiter.sv
// Round-robin read arbiter with burst locking for one shared VRAM port B (BG = req 0, SP = req 1).
// Define VRAM_ARB_PERF_EN to add grant and conflict counters.
module vram_rd_arbiter #(
    parameter int unsigned ADDR_W    = 16,
    parameter int unsigned DATA_W    = 32,
    parameter int unsigned READ_LAT  = 1,
    parameter int unsigned MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              bg_req_valid,
    input  logic              bg_req_lock,
    input  logic [ADDR_W-1:0] bg_req_addr,
    output logic              bg_req_ready,
    output logic              bg_rsp_valid,
    output logic [DATA_W-1:0] bg_rsp_data,
    input  logic              sp_req_valid,
    input  logic              sp_req_lock,
    input  logic [ADDR_W-1:0] sp_req_addr,
    output logic              sp_req_ready,
    output logic              sp_rsp_valid,
    output logic [DATA_W-1:0] sp_rsp_data,
    output logic              ram_en,
    output logic [ADDR_W-1:0] ram_addr,
    output logic              ram_we,
    input  logic [DATA_W-1:0] ram_dout,
    output logic              busy
`ifdef VRAM_ARB_PERF_EN
    ,
    output logic [31:0]       bg_grant_cnt,
    output logic [31:0]       sp_grant_cnt,
    output logic [31:0]       conflict_cnt
`endif
);

    typedef enum logic [1:0] {IDLE, OWN_BG, OWN_SP} state_t;

    localparam logic [7:0] MAX_B = 8'(MAX_BURST);

    state_t            state_q, state_d;
    logic              last_sp_q, last_sp_d;
    logic [7:0]        burst_cnt_q, burst_cnt_d;
    logic              gnt_bg, gnt_sp, keep_bg, keep_sp, rr_last_sp;
    logic              ram_en_q;
    logic [ADDR_W-1:0] ram_addr_q;
    logic [READ_LAT:0] tag_vld_q, tag_sp_q;
    logic [DATA_W-1:0] bg_data_q, sp_data_q;

    assign keep_bg = (state_q == OWN_BG) && bg_req_valid && bg_req_lock && (burst_cnt_q < MAX_B);
    assign keep_sp = (state_q == OWN_SP) && sp_req_valid && sp_req_lock && (burst_cnt_q < MAX_B);

    always_comb begin
        state_d     = state_q;
        last_sp_d   = last_sp_q;
        burst_cnt_d = burst_cnt_q;
        gnt_bg      = 1'b0;
        gnt_sp      = 1'b0;
        rr_last_sp  = last_sp_q;
        if (keep_bg) begin
            gnt_bg      = 1'b1;
            burst_cnt_d = burst_cnt_q + 8'd1;
        end else if (keep_sp) begin
            gnt_sp      = 1'b1;
            burst_cnt_d = burst_cnt_q + 8'd1;
        end else begin
            // Releasing owner becomes last_owner, then same-cycle round-robin avoids a bubble
            if (state_q == OWN_BG) rr_last_sp = 1'b0;
            if (state_q == OWN_SP) rr_last_sp = 1'b1;
            last_sp_d = rr_last_sp;
            if (bg_req_valid && (!sp_req_valid || rr_last_sp)) begin
                gnt_bg = 1'b1;
            end else if (sp_req_valid) begin
                gnt_sp = 1'b1;
            end
            if (gnt_bg) begin
                last_sp_d   = 1'b0;
                state_d     = bg_req_lock ? OWN_BG : IDLE;
                burst_cnt_d = bg_req_lock ? 8'd1 : 8'd0;
            end else if (gnt_sp) begin
                last_sp_d   = 1'b1;
                state_d     = sp_req_lock ? OWN_SP : IDLE;
                burst_cnt_d = sp_req_lock ? 8'd1 : 8'd0;
            end else begin
                state_d     = IDLE;
                burst_cnt_d = 8'd0;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= IDLE;
            last_sp_q   <= 1'b1;
            burst_cnt_q <= 8'd0;
            ram_en_q    <= 1'b0;
            ram_addr_q  <= '0;
            tag_vld_q   <= '0;
            tag_sp_q    <= '0;
            bg_data_q   <= '0;
            sp_data_q   <= '0;
        end else begin
            state_q     <= state_d;
            last_sp_q   <= last_sp_d;
            burst_cnt_q <= burst_cnt_d;
            ram_en_q    <= gnt_bg | gnt_sp;
            if (gnt_bg) ram_addr_q <= bg_req_addr;
            else if (gnt_sp) ram_addr_q <= sp_req_addr;
            tag_vld_q   <= {tag_vld_q[READ_LAT-1:0], gnt_bg | gnt_sp};
            tag_sp_q    <= {tag_sp_q[READ_LAT-1:0], gnt_sp};
            if (bg_rsp_valid) bg_data_q <= ram_dout;
            if (sp_rsp_valid) sp_data_q <= ram_dout;
        end
    end

    assign bg_req_ready = gnt_bg;
    assign sp_req_ready = gnt_sp;
    assign ram_en       = ram_en_q;
    assign ram_addr     = ram_addr_q;
    assign ram_we       = 1'b0;
    assign busy         = (|tag_vld_q) | ram_en_q;

    // Response data is passed straight through on the valid cycle and held afterwards
    assign bg_rsp_valid = tag_vld_q[READ_LAT] & ~tag_sp_q[READ_LAT];
    assign sp_rsp_valid = tag_vld_q[READ_LAT] &  tag_sp_q[READ_LAT];
    assign bg_rsp_data  = bg_rsp_valid ? ram_dout : bg_data_q;
    assign sp_rsp_data  = sp_rsp_valid ? ram_dout : sp_data_q;

`ifdef VRAM_ARB_PERF_EN
    logic [31:0] bg_cnt_q, sp_cnt_q, conf_cnt_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            bg_cnt_q   <= '0;
            sp_cnt_q   <= '0;
            conf_cnt_q <= '0;
        end else begin
            if (gnt_bg) bg_cnt_q <= bg_cnt_q + 32'd1;
            if (gnt_sp) sp_cnt_q <= sp_cnt_q + 32'd1;
            if (bg_req_valid && sp_req_valid) conf_cnt_q <= conf_cnt_q + 32'd1;
        end
    end

    assign bg_grant_cnt = bg_cnt_q;
    assign sp_grant_cnt = sp_cnt_q;
    assign conflict_cnt = conf_cnt_q;
`endif

endmodule

// File: tb/tb_vram_rd_arbiter.sv
// Directed bench for vram_rd_arbiter: instance A uses READ_LAT=1, instance B uses READ_LAT=3.
module tb_vram_rd_arbiter;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    logic        rst_a, bgv_a, bgl_a, spv_a, spl_a;
    logic [15:0] bga_a, spa_a, addr_a;
    logic        bgr_a, bgrv_a, spr_a, sprv_a, en_a, we_a, busy_a;
    logic [31:0] bgd_a, spd_a, dout_a;

    logic        rst_b, bgv_b, bgl_b, spv_b, spl_b;
    logic [15:0] bga_b, spa_b, addr_b;
    logic        bgr_b, bgrv_b, spr_b, sprv_b, en_b, we_b, busy_b;
    logic [31:0] bgd_b, spd_b, dout_b;
    logic [31:0] pipe_b1, pipe_b2;

`ifdef VRAM_ARB_PERF_EN
    logic [31:0] bgc_a, spc_a, cfc_a, bgc_b, spc_b, cfc_b;
`endif

    vram_rd_arbiter #(.ADDR_W(16), .DATA_W(32), .READ_LAT(1), .MAX_BURST(8)) u_dut_a (
        .clk(clk), .rst(rst_a),
        .bg_req_valid(bgv_a), .bg_req_lock(bgl_a), .bg_req_addr(bga_a), .bg_req_ready(bgr_a),
        .bg_rsp_valid(bgrv_a), .bg_rsp_data(bgd_a),
        .sp_req_valid(spv_a), .sp_req_lock(spl_a), .sp_req_addr(spa_a), .sp_req_ready(spr_a),
        .sp_rsp_valid(sprv_a), .sp_rsp_data(spd_a),
        .ram_en(en_a), .ram_addr(addr_a), .ram_we(we_a), .ram_dout(dout_a), .busy(busy_a)
`ifdef VRAM_ARB_PERF_EN
        , .bg_grant_cnt(bgc_a), .sp_grant_cnt(spc_a), .conflict_cnt(cfc_a)
`endif
    );

    vram_rd_arbiter #(.ADDR_W(16), .DATA_W(32), .READ_LAT(3), .MAX_BURST(8)) u_dut_b (
        .clk(clk), .rst(rst_b),
        .bg_req_valid(bgv_b), .bg_req_lock(bgl_b), .bg_req_addr(bga_b), .bg_req_ready(bgr_b),
        .bg_rsp_valid(bgrv_b), .bg_rsp_data(bgd_b),
        .sp_req_valid(spv_b), .sp_req_lock(spl_b), .sp_req_addr(spa_b), .sp_req_ready(spr_b),
        .sp_rsp_valid(sprv_b), .sp_rsp_data(spd_b),
        .ram_en(en_b), .ram_addr(addr_b), .ram_we(we_b), .ram_dout(dout_b), .busy(busy_b)
`ifdef VRAM_ARB_PERF_EN
        , .bg_grant_cnt(bgc_b), .sp_grant_cnt(spc_b), .conflict_cnt(cfc_b)
`endif
    );

    // RAM models: data = addr + 0x1000, latency 1 (A) and 3 (B)
    always @(posedge clk) dout_a <= {16'h0000, addr_a} + 32'h1000;
    always @(posedge clk) begin
        pipe_b1 <= {16'h0000, addr_b} + 32'h1000;
        pipe_b2 <= pipe_b1;
        dout_b  <= pipe_b2;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic reset_a();
        bgv_a = 1'b0; spv_a = 1'b0; bgl_a = 1'b0; spl_a = 1'b0;
        rst_a = 1'b1;
        step();
        step();
        rst_a = 1'b0;
    endtask

    logic [15:0] exp_g;
    logic [15:0] prev_addr;
    int          k;
    int          j;

    initial begin
        rst_a = 1'b1; rst_b = 1'b1;
        bgv_a = 0; bgl_a = 0; spv_a = 0; spl_a = 0; bga_a = '0; spa_a = '0;
        bgv_b = 0; bgl_b = 0; spv_b = 0; spl_b = 0; bga_b = '0; spa_b = '0;
        #1;
        check("rst_en", {31'd0, en_a}, 0);
        check("rst_busy", {31'd0, busy_a}, 0);
        check("rst_rspv", {30'd0, bgrv_a, sprv_a}, 0);
        check("rst_data", bgd_a | spd_a, 0);
        check("rst_we", {31'd0, we_a}, 0);
        step();
        step();
        rst_a = 1'b0; rst_b = 1'b0;

        // Single BG read
        bgv_a = 1'b1; bga_a = 16'h0010; #1;
        check("t1_bg_rdy", {31'd0, bgr_a}, 1);
        check("t1_sp_rdy", {31'd0, spr_a}, 0);
        step();
        bgv_a = 1'b0; #1;
        check("t1_en", {31'd0, en_a}, 1);
        check("t1_addr", {16'd0, addr_a}, 32'h0010);
        check("t1_early_rsp", {31'd0, bgrv_a}, 0);
        check("t1_busy", {31'd0, busy_a}, 1);
        step(); #1;
        check("t1_bg_rspv", {31'd0, bgrv_a}, 1);
        check("t1_bg_data", bgd_a, 32'h0000_1010);
        check("t1_sp_rspv", {31'd0, sprv_a}, 0);
        step(); #1;
        check("t1_rspv_off", {31'd0, bgrv_a}, 0);
        check("t1_hold", bgd_a, 32'h0000_1010);
        check("t1_en_off", {31'd0, en_a}, 0);
        check("t1_idle", {31'd0, busy_a}, 0);

        // Both valid, no lock: alternate BG, SP
        reset_a();
        for (int c = 0; c < 10; c++) begin
            bgv_a = (c < 8); spv_a = (c < 8);
            bga_a = 16'h0100 + 16'(c); spa_a = 16'h0200 + 16'(c); #1;
            if (c < 8) begin
                check("t2_bg_rdy", {31'd0, bgr_a}, (c % 2 == 0) ? 1 : 0);
                check("t2_sp_rdy", {31'd0, spr_a}, (c % 2 == 1) ? 1 : 0);
            end
            if (c >= 2) begin
                j = c - 2;
                check("t2_bg_rspv", {31'd0, bgrv_a}, (j % 2 == 0) ? 1 : 0);
                check("t2_sp_rspv", {31'd0, sprv_a}, (j % 2 == 1) ? 1 : 0);
                if (j % 2 == 0) check("t2_bg_data", bgd_a, 32'h1100 + 32'(j));
                else            check("t2_sp_data", spd_a, 32'h1200 + 32'(j));
            end
            step();
        end

        // BG locked 12-beat stream against SP: 8 BG, SP, 4 BG, then SP
        reset_a();
        exp_g = 16'h1EFF;
        k = 0;
        prev_addr = '0;
        for (int c = 0; c < 16; c++) begin
            bgv_a = (k < 12); bgl_a = (k < 12); bga_a = 16'h0300 + 16'(k);
            spv_a = 1'b1; spa_a = 16'h0400; #1;
            check("t3_bg_rdy", {31'd0, bgr_a}, {31'd0, exp_g[c]});
            check("t3_sp_rdy", {31'd0, spr_a}, {31'd0, ~exp_g[c]});
            if (c > 0) begin
                check("t3_en", {31'd0, en_a}, 1);
                check("t3_addr", {16'd0, addr_a}, {16'd0, prev_addr});
            end
            prev_addr = exp_g[c] ? 16'h0300 + 16'(k) : 16'h0400;
            if (exp_g[c]) k++;
            step();
        end
        spv_a = 1'b0; bgl_a = 1'b0; bgv_a = 1'b0;
        step();

        // READ_LAT=3: BG, SP, BG back to back
        for (int c = 0; c < 8; c++) begin
            bgv_b = (c == 0 || c == 2); spv_b = (c == 1);
            bga_b = (c == 0) ? 16'h0050 : 16'h0070; spa_b = 16'h0060; #1;
            if (c < 3) begin
                check("t4_bg_rdy", {31'd0, bgr_b}, (c != 1) ? 1 : 0);
                check("t4_sp_rdy", {31'd0, spr_b}, (c == 1) ? 1 : 0);
            end
            check("t4_bg_rspv", {31'd0, bgrv_b}, (c == 4 || c == 6) ? 1 : 0);
            check("t4_sp_rspv", {31'd0, sprv_b}, (c == 5) ? 1 : 0);
            if (c == 4) check("t4_bg_d0", bgd_b, 32'h1050);
            if (c == 5) check("t4_sp_d", spd_b, 32'h1060);
            if (c == 6) check("t4_bg_d1", bgd_b, 32'h1070);
            step();
        end

        // Reset with reads in flight (SP then BG issued, so BG is last owner)
        spv_b = 1'b1; spa_b = 16'h0090; #1;
        check("t5_sp_rdy", {31'd0, spr_b}, 1);
        step();
        spv_b = 1'b0; bgv_b = 1'b1; bga_b = 16'h0080; #1;
        check("t5_bg_rdy", {31'd0, bgr_b}, 1);
        step();
        bgv_b = 1'b0; step();
        check("t5_busy_pre", {31'd0, busy_b}, 1);
        rst_b = 1'b1; #1;
        check("t5_rst_rspv", {30'd0, bgrv_b, sprv_b}, 0);
        check("t5_rst_busy", {31'd0, busy_b}, 0);
        step();
        check("t5_rst_rspv2", {30'd0, bgrv_b, sprv_b}, 0);
        check("t5_rst_en", {31'd0, en_b}, 0);
        rst_b = 1'b0;
        step();
        check("t5_post_rspv", {30'd0, bgrv_b, sprv_b}, 0);
        step();
        check("t5_post_rspv2", {30'd0, bgrv_b, sprv_b}, 0);
        check("t5_post_busy", {31'd0, busy_b}, 0);
        bgv_b = 1'b1; spv_b = 1'b1; #1;
        check("t5_tie_bg", {31'd0, bgr_b}, 1);
        check("t5_tie_sp", {31'd0, spr_b}, 0);
        step();
        bgv_b = 1'b0; spv_b = 1'b0;
        step();

`ifdef VRAM_ARB_PERF_EN
        reset_a();
        check("t6_rst_cnt", bgc_a | spc_a | cfc_a, 0);
        bgv_a = 1'b1; spv_a = 1'b1;
        for (int c = 0; c < 10; c++) step();
        bgv_a = 1'b0; spv_a = 1'b0;
        step();
        check("t6_bg_cnt", bgc_a, 5);
        check("t6_sp_cnt", spc_a, 5);
        check("t6_conf_cnt", cfc_a, 10);
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
